// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// Holds the default widths, the hard-wired zero register index and the priority pointer encoding.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;
    localparam int CNT_W    = 16;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_e;

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback requesters, the stall input and the register-file write port.
// master = requester/consumer side, slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
);
    logic              stall;

    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;

    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;

    logic              write_enable;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [15:0]       conflict_cnt;

    modport master (
        output stall,
        output a_valid, a_reg, a_data,
        input  a_ready,
        output b_valid, b_reg, b_data,
        input  b_ready,
        input  write_enable, write_reg, write_data, conflict_cnt
    );

    modport slave (
        input  stall,
        input  a_valid, a_reg, a_data,
        output a_ready,
        input  b_valid, b_reg, b_data,
        output b_ready,
        output write_enable, write_reg, write_data, conflict_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grants, one-bit priority pointer that
// flips toward the other requester after every accepted transfer.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic a_valid,
    input  logic b_valid,
    output logic gnt_a,
    output logic gnt_b
);

    pri_e ptr_q;
    pri_e ptr_d;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset && !stall) begin
            if (a_valid && b_valid) begin
                gnt_a = (ptr_q == PRI_A);
                gnt_b = (ptr_q == PRI_B);
            end else begin
                gnt_a = a_valid;
                gnt_b = b_valid;
            end
        end
    end

    // A grant is always a transfer, since a grant is only given to a valid requester.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_a) begin
            ptr_d = PRI_B;
        end else if (gnt_b) begin
            ptr_d = PRI_A;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= PRI_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates ALU and load writebacks onto a single register-file write port with one-cycle
// registered latency, suppresses writes to the zero register and counts contended cycles.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    logic gnt_a;
    logic gnt_b;

    logic              write_enable_q, write_enable_d;
    logic [ADDR_W-1:0] write_reg_q,    write_reg_d;
    logic [DATA_W-1:0] write_data_q,   write_data_d;
    logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .stall   (bus.stall),
        .a_valid (bus.a_valid),
        .b_valid (bus.b_valid),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    assign bus.a_ready = gnt_a;
    assign bus.b_ready = gnt_b;

    // Index 0 transfers are accepted but never strobe the register file.
    always_comb begin
        write_enable_d = 1'b0;
        write_reg_d    = write_reg_q;
        write_data_d   = write_data_q;
        if (gnt_a) begin
            write_enable_d = (bus.a_reg != ADDR_W'(ZERO_REG));
            write_reg_d    = bus.a_reg;
            write_data_d   = bus.a_data;
        end else if (gnt_b) begin
            write_enable_d = (bus.b_reg != ADDR_W'(ZERO_REG));
            write_reg_d    = bus.b_reg;
            write_data_d   = bus.b_data;
        end
    end

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (bus.a_valid && bus.b_valid && !bus.stall) begin
            conflict_cnt_d = sat_inc(conflict_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_enable_q <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            write_enable_q <= write_enable_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.write_enable = write_enable_q;
    assign bus.write_reg    = write_reg_q;
    assign bus.write_data   = write_data_q;
    assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, write-data width.
REQ-002 Parameter: ADDR_W, 5, register-index width (32 registers).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: stall  input  1  when high, no grant issued this cycle.
REQ-006 Port: a_valid / a_ready  input / output  1 / 1  requester A handshake (ALU writeback).
REQ-007 Port: a_reg / a_data  input  ADDR_W / DATA_W  requester A destination index and data.
REQ-008 Port: b_valid / b_ready  input / output  1 / 1  requester B handshake (load writeback).
REQ-009 Port: b_reg / b_data  input  ADDR_W / DATA_W  requester B destination index and data.
REQ-010 Port: write_enable  output  1  register-file write strobe.
REQ-011 Port: write_reg / write_data  output  ADDR_W / DATA_W  register-file write index and data.
REQ-012 Port: conflict_cnt  output  16  saturating count of cycles with both requesters valid and stall low.

Function
REQ-013 Transfer on a requester = valid and ready both high at a rising edge.
REQ-014 a_ready/b_ready combinational from valids, stall and priority pointer; at most one high per cycle.
REQ-015 stall high or reset high -> a_ready = b_ready = 0.
REQ-016 Single valid requester, stall low -> that requester granted, independent of pointer.
REQ-017 Both valid, stall low -> grant the requester named by the priority pointer.
REQ-018 Priority pointer is one state bit, values PRI_A / PRI_B; after a transfer by A it becomes PRI_B, after a transfer by B it becomes PRI_A; unchanged in cycles with no transfer.
REQ-019 Transfer at edge t -> write_enable = 1 with write_reg/write_data equal to the accepted reg/data during cycle t+1 (one-cycle latency, registered outputs).
REQ-020 No transfer at edge t -> write_enable = 0 in cycle t+1; write_reg/write_data hold their previous values.
REQ-021 Transfer with destination index 0 is accepted (ready high) but write_enable stays 0 in cycle t+1.
REQ-022 Requesters may target the same index in the same cycle; the loser waits, gets granted next cycle if still valid, and its write lands one cycle after the winner's (last-granted value wins).
REQ-023 conflict_cnt increments by 1 each cycle with a_valid, b_valid both high and stall low; holds at 16'hFFFF.
REQ-024 Throughput: one transfer per cycle sustained; no bubble between back-to-back grants.

Reset
REQ-025 Reset high at an edge -> write_enable = 0, write_reg = 0, write_data = 0, pointer = PRI_A, conflict_cnt = 0.
REQ-026 Reset asserted mid-operation discards any grant in that cycle; no write issued in the following cycle.
REQ-027 First cycle after reset release, both valid -> A granted.

Structure
REQ-028 Shared package regfile_pkg holds DATA_W, ADDR_W, ZERO_REG = 0 and the pointer enum (PRI_A, PRI_B).
REQ-029 Sub-module rr_arbiter2: 2-way round-robin arbiter (valids, stall, reset in; grants out; owns pointer).
REQ-030 Output registers and conflict counter reside in regfile_write_arbiter.

Verification
REQ-031 After reset, A only: a_reg=3, a_data=32'h0000_00AA -> a_ready=1 same cycle; next cycle write_enable=1, write_reg=3, write_data=32'hAA.
REQ-032 Both valid 4 cycles (A reg 1, B reg 2) -> grants A,B,A,B; write_reg sequence 1,2,1,2 one cycle later; conflict_cnt = 4 while both valid.
REQ-033 A valid reg 0, data 32'hFFFF_FFFF -> a_ready=1, write_enable stays 0 next cycle.
REQ-034 Both valid, stall high 3 cycles -> both ready 0, write_enable 0, conflict_cnt unchanged; stall low -> grant per pointer.
REQ-035 Both target reg 5 (A=32'h11, B=32'h22), pointer PRI_A -> writes 5<=0x11 then 5<=0x22 in consecutive cycles.
REQ-036 Reset asserted in the cycle A is granted -> no write next cycle, pointer PRI_A, conflict_cnt = 0; counter forced to 16'hFFFF saturates on further conflicts.
